// File: rtl/linear_layer.sv
`default_nettype none
// ============================================================================
// Module      : linear_layer
// Description : Fully-connected int8 layer engine. Streams one 16-input weight
//               segment per cycle from an external synchronous ROM (1-cycle
//               registered read latency), accumulates OUT signed 32-bit dot
//               products, adds a per-output bias, applies an arithmetic
//               rescale shift and 16-bit saturation, then presents all
//               results in parallel with a one-cycle done pulse.
//
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous reset, ACTIVE-HIGH despite its name
//               trigger  - start pulse, honoured in IDLE only
//               x        - IN*16 signed int8 inputs, element i = x[i*8 +: 8]
//               now_seg  - weight-ROM address (current segment index)
//               w        - weight word for the previously issued address;
//                          weight(o,j) = w[(o*16+j)*8 +: 8], top byte unused
//               b        - bias word: bias o = b[o*16 +: 16] (signed),
//                          shift = b[OUT*16 +: 8] (low 5 bits used)
//               fin      - one-cycle done pulse
//               out      - signed results, out o = out[o*16 +: 16]
//
// Options     : LINEAR_RELU_EN - when defined, negative saturated results are
//               clamped to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module linear_layer #(
    parameter int IN  = 16,
    parameter int OUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    input  logic [IN*128-1:0]    x,
    output logic [7:0]           now_seg,
    input  logic [OUT*128+7:0]   w,
    input  logic [OUT*16+7:0]    b,
    output logic                 fin,
    output logic [OUT*16-1:0]    out
);

    localparam int         c_XW       = $clog2(IN * 128);
    localparam logic [7:0] c_LAST_SEG = 8'(IN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ACC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic              w_done;

    logic [7:0]        r_now_seg;
    // Address issued one cycle earlier: this is the segment whose weights are
    // on w right now, so it selects the matching x slice.
    logic [7:0]        r_seg_prev;
    logic              r_fin;
    logic [OUT*16-1:0] r_out;

    logic [c_XW-1:0]   w_x_base;
    logic [127:0]      w_x_seg;
    logic [4:0]        w_shift;
    logic [OUT*16-1:0] w_res;

    // Reserved bits of the weight and bias words are intentionally ignored.
    logic              w_unused_bits;
    assign w_unused_bits = ^{w[OUT*128 +: 8], b[OUT*16+5 +: 3]};

    assign w_x_base = c_XW'(r_seg_prev) << 7;
    assign w_x_seg  = x[w_x_base +: 128];
    assign w_shift  = b[OUT*16 +: 5];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_acc_clr   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // ROM is producing segment 0 during this cycle.
                w_state_nxt = S_ACC;
            end
            S_ACC: begin
                w_acc_en = 1'b1;
                if (r_seg_prev == c_LAST_SEG) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address sequencing, output register and done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_now_seg  <= 8'd0;
            r_seg_prev <= 8'd0;
            r_fin      <= 1'b0;
            r_out      <= '0;
        end else begin
            r_fin      <= 1'b0;
            r_seg_prev <= r_now_seg;
            case (r_state)
                S_IDLE: begin
                    r_now_seg <= 8'd0;
                end
                S_FETCH, S_ACC: begin
                    if (r_now_seg < c_LAST_SEG) begin
                        r_now_seg <= r_now_seg + 8'd1;
                    end
                end
                S_DONE: begin
                    r_now_seg <= 8'd0;
                    r_out     <= w_res;
                    r_fin     <= 1'b1;
                end
                default: begin
                    r_now_seg <= 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-output datapath: segment dot product, accumulator, post-process
    // ------------------------------------------------------------------
    for (genvar o = 0; o < OUT; o++) begin : g_out
        logic signed [15:0] w_prod [16];
        logic signed [31:0] w_seg_sum;
        logic signed [31:0] r_acc;
        logic signed [31:0] w_biased;
        logic signed [31:0] w_shifted;
        logic signed [15:0] w_sat;
        logic signed [15:0] w_final;

        always_comb begin
            w_seg_sum = '0;
            for (int j = 0; j < 16; j++) begin
                w_prod[j] = 16'(signed'(w_x_seg[j*8 +: 8]))
                          * 16'(signed'(w[(o*16+j)*8 +: 8]));
                w_seg_sum = w_seg_sum + 32'(w_prod[j]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n) begin
                r_acc <= '0;
            end else if (w_acc_clr) begin
                r_acc <= '0;
            end else if (w_acc_en) begin
                r_acc <= r_acc + w_seg_sum;
            end
        end

        always_comb begin
            w_biased  = r_acc + 32'(signed'(b[o*16 +: 16]));
            w_shifted = w_biased >>> w_shift;
            if (w_shifted > 32'sd32767) begin
                w_sat = 16'sh7fff;
            end else if (w_shifted < -32'sd32768) begin
                w_sat = 16'sh8000;
            end else begin
                w_sat = w_shifted[15:0];
            end
`ifdef LINEAR_RELU_EN
            w_final = w_sat[15] ? 16'sd0 : w_sat;
`else
            w_final = w_sat;
`endif
        end

        assign w_res[o*16 +: 16] = w_final;
    end

    assign now_seg = r_now_seg;
    assign fin     = r_fin;
    assign out     = r_out;

    // w_done marks the result-commit cycle; kept for readability of the FSM.
    logic w_unused_done;
    assign w_unused_done = w_done;

endmodule
`default_nettype wire

// File: tb/tb_linear_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_linear_layer
// Description : Directed self-checking bench for linear_layer. A registered
//               ROM model supplies weight words one cycle after each address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linear_layer;

    localparam int NI = 16;
    localparam int NO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trigger;
    logic [NI*128-1:0] x;
    logic [7:0]        now_seg;
    logic [NO*128+7:0] w;
    logic [NO*16+7:0]  b;
    logic              fin;
    logic [NO*16-1:0]  out;

    int checks = 0;
    int errors = 0;

    // ROM model controls: 0 = every weight rom_w, 1 = output o weight o-8,
    // 2 = weight 1 only in segment rom_seg, else 0.
    int         rom_mode = 0;
    int         rom_w    = 1;
    logic [7:0] rom_seg  = 8'd0;

    linear_layer #(.IN(NI), .OUT(NO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (trigger),
        .x       (x),
        .now_seg (now_seg),
        .w       (w),
        .b       (b),
        .fin     (fin),
        .out     (out)
    );

    always #5 clk = ~clk;

    function automatic logic [NO*128+7:0] rom_word(input logic [7:0] seg);
        logic [NO*128+7:0] r;
        r = '0;
        for (int o = 0; o < NO; o++) begin
            for (int j = 0; j < 16; j++) begin
                int v;
                case (rom_mode)
                    0:       v = rom_w;
                    1:       v = o - 8;
                    default: v = (seg == rom_seg) ? 1 : 0;
                endcase
                r[(o*16+j)*8 +: 8] = 8'(v);
            end
        end
        r[NO*128 +: 8] = 8'hA5;
        return r;
    endfunction

    always @(posedge clk) w <= rom_word(now_seg);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_all(input string tag, input int base, input int step);
        for (int o = 0; o < NO; o++) begin
            int e;
            logic [15:0] v;
            e = base + step * o;
`ifdef LINEAR_RELU_EN
            if (e < 0) e = 0;
`endif
            v = out[o*16 +: 16];
            chk($sformatf("%s out[%0d]", tag, o), {{16{v[15]}}, v}, e);
        end
    endtask

    task automatic set_x_mod();
        for (int i = 0; i < NI*16; i++) x[i*8 +: 8] = 8'(i % 128);
    endtask

    task automatic set_x_const(input int v);
        for (int i = 0; i < NI*16; i++) x[i*8 +: 8] = 8'(v);
    endtask

    task automatic set_bias(input int step, input int sh);
        for (int o = 0; o < NO; o++) b[o*16 +: 16] = 16'(o * step);
        b[NO*16 +: 8] = 8'(sh);
    endtask

    // Pulse trigger, then wait (bounded) for fin; checks latency and that fin
    // drops after one cycle. Optionally checks the ROM address sequence.
    task automatic run(input string tag, input bit check_seg);
        int  lat;
        bit  seen;
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        if (check_seg) chk({tag, " now_seg[0]"}, 32'(now_seg), 0);
        seen = 1'b0;
        lat  = -1;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (check_seg && k <= 15) chk($sformatf("%s now_seg[%0d]", tag, k), 32'(now_seg), k);
            if (fin === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        chk({tag, " latency"}, lat, 18);
        @(posedge clk);
        #1 chk({tag, " fin drop"}, 32'(fin), 0);
    endtask

    initial begin
        int nfin;
        int first;

        rst_n   = 1'b1;
        trigger = 1'b0;
        set_x_mod();
        set_bias(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset fin", 32'(fin), 0);
        chk("reset now_seg", 32'(now_seg), 0);
        check_all("reset", 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Basic sum: sum of i mod 128 over 256 inputs = 16256
        rom_mode = 0; rom_w = 1;
        run("basic", 1'b1);
        check_all("basic", 16256, 0);

        // Only segment 3 weighted: sum of 48..63 = 888 (checks alignment)
        rom_mode = 2; rom_seg = 8'd3;
        run("seg3", 1'b0);
        check_all("seg3", 888, 0);

        // Bias o, shift 4: (16256 + o) >>> 4 = 1016 for all o
        rom_mode = 0; rom_w = 1;
        set_bias(1, 4);
        run("shift_bias", 1'b0);
        check_all("shift_bias", 1016, 0);

        // Positive saturation: 256 * 127 * 127 -> 32767
        set_bias(0, 0);
        set_x_const(127);
        rom_w = 127;
        run("sat_pos", 1'b0);
        check_all("sat_pos", 32767, 0);

        // Negative saturation: 256 * 127 * -128 -> -32768 (0 with ReLU)
        rom_w = -128;
        run("sat_neg", 1'b0);
        check_all("sat_neg", -32768, 0);

        // Per-output weights o-8, x = 1: out[o] = 256*(o-8)
        rom_mode = 1;
        set_x_const(1);
        run("per_out", 1'b0);
        check_all("per_out", -2048, 256);

        // Second trigger 5 cycles into a run is ignored
        rom_mode = 0; rom_w = 1;
        set_x_mod();
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        nfin = 0; first = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) trigger = 1'b1;
            if (k == 5) trigger = 1'b0;
            if (fin === 1'b1) begin
                nfin++;
                if (first < 0) first = k;
            end
        end
        chk("busy fin count", nfin, 1);
        chk("busy fin time", first, 18);
        check_all("busy", 16256, 0);

        // Reset at cycle 8 of a run: no fin, outputs cleared
        rom_mode = 1;
        set_x_const(1);
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
        nfin = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 7) rst_n = 1'b1;
            if (k == 8) rst_n = 1'b0;
            if (fin === 1'b1) nfin++;
        end
        chk("midreset fin count", nfin, 0);
        chk("midreset now_seg", 32'(now_seg), 0);
        check_all("midreset", 0, 0);
        run("after_reset", 1'b0);
        check_all("after_reset", -2048, 256);

        // Trigger coincident with reset: reset wins, no run starts
        @(negedge clk);
        rst_n = 1'b1; trigger = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0; trigger = 1'b0;
        nfin = 0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (fin === 1'b1) nfin++;
        end
        chk("rst_trig fin count", nfin, 0);
        check_all("rst_trig", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
